// File: rtl/pipelined_addsub.sv
// pipelined_addsub: segmented-carry pipelined add/sub with valid/ready; define PIPELINED_ADDSUB_SATURATE_EN to clamp sum on overflow
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int SEG = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand0,
    input  logic [WIDTH-1:0] operand1,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int STAGES = WIDTH / SEG;
    localparam int L = STAGES - 1;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q, c_d, v_q, v_d, cy;
    logic              ovf_q, ovf_d, adv;
    assign adv       = !(v_q[L] && !out_ready);
    assign in_ready  = adv;
    assign out_valid = v_q[L];
    assign sum       = s_q[L];
    assign cout      = c_q[L];
    assign overflow  = ovf_q;
    always_comb begin
        a_d[0] = operand0;
        b_d[0] = sub ? ~operand1 : operand1;
        s_d[0] = '0;
        v_d[0] = in_valid;
        cy[0]  = sub | cin;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
            v_d[k] = v_q[k-1];
            cy[k]  = c_q[k-1];
        end
        c_d = '0;
        for (int k = 0; k < STAGES; k++)
            {c_d[k], s_d[k][k*SEG +: SEG]} = {1'b0, a_d[k][k*SEG +: SEG]} + {1'b0, b_d[k][k*SEG +: SEG]} + {{SEG{1'b0}}, cy[k]};
        ovf_d = (a_d[L][WIDTH-1] ^ b_d[L][WIDTH-1] ^ s_d[L][WIDTH-1]) ^ c_d[L];
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        if (ovf_d)
            s_d[L] = a_d[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            s_q   <= '{default: '0};
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed table, backpressure/reset sequences and random streaming against an arithmetic model
module tb_pipelined_addsub;
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic clock = 0, reset = 1, in_valid = 0, out_ready = 1, cin = 0, sub = 0;
    logic [31:0] operand0 = 0, operand1 = 0, sum;
    logic in_ready, out_valid, cout, overflow;
    logic in_valid1 = 0, cin1 = 0, sub1 = 0, out_ready1 = 1;
    logic [15:0] a1 = 0, b1 = 0, sum1;
    logic in_ready1, out_valid1, cout1, ovf1;
    int checks = 0, errors = 0;

    typedef struct {
        logic [31:0] a, b;
        logic        ci, sb;
        logic [31:0] s;
        logic        co, ov;
        string       name;
    } vec_t;
    typedef struct {
        logic [31:0] s;
        logic        co, ov;
    } res_t;

    always #5 clock = ~clock;

    pipelined_addsub #(.WIDTH(32), .SEG(8)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .operand0(operand0), .operand1(operand1), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow));

    pipelined_addsub #(.WIDTH(16), .SEG(16)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
        .operand0(a1), .operand1(b1), .cin(cin1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1), .sum(sum1), .cout(cout1), .overflow(ovf1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic sb);
        res_t r;
        longint sa, sv, c, exact, ua, ub;
        sa = longint'($signed(a));
        sv = longint'($signed(b));
        c  = sb ? 0 : longint'(ci);
        ua = longint'(a);
        ub = longint'(b);
        exact = sb ? sa - sv : sa + sv + c;
        r.ov = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
        r.co = sb ? (a >= b) : (ua + ub + c > 64'sh0_FFFF_FFFF);
        r.s  = sb ? a - b : a + b + {31'd0, ci};
        if (SAT && r.ov) r.s = sa < 0 ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return r;
    endfunction

    task automatic run_one(input vec_t v);
        operand0 = v.a; operand1 = v.b; cin = v.ci; sub = v.sb;
        in_valid = 1; out_ready = 1;
        chk({v.name, "_in_ready"}, in_ready, 1);
        tick;
        in_valid = 0;
        repeat (2) tick;
        chk({v.name, "_early"}, out_valid, 0);
        tick;
        chk({v.name, "_valid"}, out_valid, 1);
        chk({v.name, "_sum"}, sum, v.s);
        chk({v.name, "_cout"}, cout, v.co);
        chk({v.name, "_ovf"}, overflow, v.ov);
        tick;
        chk({v.name, "_drain"}, out_valid, 0);
    endtask

    task automatic stream(input int n, input bit rnd);
        res_t exp_q[$];
        res_t r;
        int issued = 0, got = 0, first = -1, cyc = 0;
        bit pend = 0, in_x, out_x;
        logic [31:0] a = 0, b = 0;
        logic ci = 0, sb = 0;
        while (got < n && cyc < n * 20 + 50) begin
            if (issued < n && !pend) begin
                a  = rnd ? $urandom : issued + 1;
                b  = rnd ? ($urandom_range(0, 3) == 0 ? 32'h7FFF_FFFF : $urandom) : issued + 1;
                ci = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                sb = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                pend = 1;
            end
            operand0 = a; operand1 = b; cin = ci; sub = sb;
            in_valid = (issued < n) && (rnd ? $urandom_range(0, 3) != 0 : 1'b1);
            if (!rnd && first < 0 && out_valid) first = cyc;
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : !(first >= 0 && cyc < first + 3);
            #1;
            in_x  = in_valid && in_ready;
            out_x = out_valid && out_ready;
            if (!rnd && first >= 0 && cyc < first + 3) begin
                chk("bp_stall_in_ready", in_ready, 0);
                chk("bp_hold_sum", sum, 2);
            end
            if (out_x) begin
                if (exp_q.size() == 0) chk("stream_extra_out", out_valid, 0);
                else begin
                    r = exp_q.pop_front();
                    if (!rnd) chk("bp_seq_sum", sum, 64'(2 * (got + 1)));
                    chk("stream_sum", sum, r.s);
                    chk("stream_cout", cout, r.co);
                    chk("stream_ovf", overflow, r.ov);
                    got++;
                end
            end
            if (in_x) begin
                exp_q.push_back(model(a, b, ci, sb));
                issued++;
                pend = 0;
            end
            tick;
            cyc++;
        end
        in_valid = 0;
        out_ready = 1;
        chk("stream_count", 64'(got), 64'(n));
        chk("stream_leftover", 64'(exp_q.size()), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        vec_t v;
        bit seen;
        int waits;
        tbl[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, "add_ff"};
        tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "ripple"};
        tbl[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, SAT ? 32'h7FFF_FFFF : 32'h8000_0000, 1'b0, 1'b1, "pos_ovf"};
        tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf"};
        tbl[4] = '{32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0, "sub_cin_ign"};
        tbl[5] = '{32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "borrow"};
        tbl[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, SAT ? 32'h8000_0000 : 32'h0, 1'b1, 1'b1, "neg_ovf"};
        tbl[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "all_ones"};
        tbl[8] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, "seg_carry"};

        repeat (2) tick;
        reset = 0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst1_out_valid", out_valid1, 0);

        a1 = 16'h8000; b1 = 16'h8000; in_valid1 = 1;
        tick;
        in_valid1 = 0;
        chk("s1_valid", out_valid1, 1);
        chk("s1_sum", sum1, SAT ? 16'h8000 : 16'h0000);
        chk("s1_cout", cout1, 1);
        chk("s1_ovf", ovf1, 1);

        foreach (tbl[i]) run_one(tbl[i]);

        stream(8, 1'b0);

        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            operand0 = i; operand1 = 1; cin = 0; sub = 0; in_valid = 1;
            tick;
        end
        in_valid = 0;
        reset = 1;
        tick;
        reset = 0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_sum", sum, 0);
        seen = 0;
        repeat (6) begin
            tick;
            seen |= out_valid;
        end
        chk("mid_rst_residual", seen, 0);
        v = '{32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, "post_rst"};
        run_one(v);

        operand0 = 32'hFFFF_FFFF; operand1 = 32'h2; cin = 0; sub = 0;
        in_valid = 1; out_ready = 0;
        tick;
        in_valid = 0;
        waits = 0;
        while (!out_valid && waits < 10) begin
            tick;
            waits++;
        end
        chk("stall_valid", out_valid, 1);
        chk("stall_in_ready", in_ready, 0);
        repeat (2) tick;
        chk("stall_hold_sum", sum, 32'h1);
        chk("stall_hold_cout", cout, 1);
        reset = 1;
        tick;
        reset = 0;
        chk("stall_rst_valid", out_valid, 0);
        chk("stall_rst_sum", sum, 0);
        chk("stall_rst_cout", cout, 0);
        out_ready = 1;

        stream(300, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
